// File: rtl/opl3_pkg.sv
// Shared OPL3 types: register-write pulse format and host write-buffer entry.
// Host-interface defaults live here so the top and the bench agree on them.
package opl3_pkg;

  localparam int HOST_FIFO_DEPTH = 8;
  localparam int HOST_WR_SPACING = 32;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

  typedef struct packed {
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } host_fifo_entry_t;

  // Status byte carries only a 4-bit occupancy field.
  function automatic logic [3:0] sat_count4(input logic [31:0] count);
    return (count > 32'd15) ? 4'hF : count[3:0];
  endfunction

endpackage

// File: rtl/opl3_reg_fifo.sv
// Synchronous write-buffer FIFO of host_fifo_entry_t with an occupancy counter.
// A push while full is accepted only when a pop happens in the same cycle.
module opl3_reg_fifo
  import opl3_pkg::*;
#(
  parameter int DEPTH = HOST_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [16:0]   wdata_i,
  input  logic          pop_i,
  output logic [16:0]   rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  host_fifo_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= host_fifo_entry_t'(wdata_i);
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/opl3_host_if.sv
// Host-bus front end: decodes address/data port writes, buffers them and drains
// rate-limited opl3_reg_wr pulses. OPL3_HOST_STATUS_EN adds a status read port.
module opl3_host_if
  import opl3_pkg::*;
#(
  parameter int FIFO_DEPTH = HOST_FIFO_DEPTH,
  parameter int WR_SPACING = HOST_WR_SPACING,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          ic_n,
  input  logic          host_wr_en,
  input  logic [1:0]    host_addr,
  input  logic [7:0]    host_data,
  input  logic          overflow_clr,
`ifdef OPL3_HOST_STATUS_EN
  input  logic          host_rd_en,
  output logic [7:0]    host_rd_data,
`endif
  output logic [17:0]   opl3_reg_wr,
  output logic          fifo_full,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int SW = (WR_SPACING > 1) ? $clog2(WR_SPACING) : 1;

  logic [7:0]   addr_latch_q, addr_latch_d;
  logic         bank_latch_q, bank_latch_d;
  logic [SW-1:0] cnt_q, cnt_d;
  opl3_reg_wr_t reg_wr_q, reg_wr_d;
  logic         overflow_q, overflow_d;

  logic         push, pop, fifo_empty, overflow_set, overflow_clear;
  logic [16:0]  head_raw;
  host_fifo_entry_t head;

  assign push         = host_wr_en && host_addr[0];
  assign pop          = (cnt_q == '0) && !fifo_empty;
  assign overflow_set = push && fifo_full && !pop;
  assign head         = host_fifo_entry_t'(head_raw);

  opl3_reg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n_i (ic_n),
    .push_i  (push),
    .wdata_i ({bank_latch_q, addr_latch_q, host_data}),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef OPL3_HOST_STATUS_EN
  logic [7:0] rd_data_q, rd_data_d;
  assign overflow_clear = overflow_clr || host_rd_en;

  always_comb begin
    rd_data_d = rd_data_q;
    if (host_rd_en)
      rd_data_d = {fifo_full, overflow_q, fifo_empty, 1'b0, sat_count4(32'(fifo_count))};
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign host_rd_data = rd_data_q;
`else
  assign overflow_clear = overflow_clr;
`endif

  always_comb begin
    addr_latch_d = addr_latch_q;
    bank_latch_d = bank_latch_q;
    cnt_d        = cnt_q;
    reg_wr_d     = reg_wr_q;
    reg_wr_d.valid = 1'b0;
    overflow_d   = overflow_q;

    if (host_wr_en && !host_addr[0]) begin
      addr_latch_d = host_data;
      bank_latch_d = host_addr[1];
    end

    // Pop reloads the spacing counter so the next pulse is WR_SPACING cycles later.
    if (pop) begin
      reg_wr_d = {1'b1, head};
      cnt_d    = SW'(WR_SPACING - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SW'(1);
    end

    if (overflow_set)        overflow_d = 1'b1;
    else if (overflow_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      addr_latch_q <= '0;
      bank_latch_q <= 1'b0;
      cnt_q        <= '0;
      reg_wr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      addr_latch_q <= addr_latch_d;
      bank_latch_q <= bank_latch_d;
      cnt_q        <= cnt_d;
      reg_wr_q     <= reg_wr_d;
      overflow_q   <= overflow_d;
    end
  end

  assign opl3_reg_wr = reg_wr_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_opl3_host_if.sv
// Bench for opl3_host_if: vector table for port decode/latency, hand sequences for
// spacing, overflow, full-with-pop and async reset. Honours OPL3_HOST_STATUS_EN.
module tb_opl3_host_if;

  logic        clk = 1'b0;
  logic        ic_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [1:0]  host_addr = 2'b00;
  logic [7:0]  host_data = 8'h00;
  logic        overflow_clr = 1'b0;
  logic [17:0] opl3_reg_wr;
  logic        fifo_full;
  logic [3:0]  fifo_count;
  logic        overflow;
`ifdef OPL3_HOST_STATUS_EN
  logic        host_rd_en = 1'b0;
  logic [7:0]  host_rd_data;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [16:0] p; } pulse_t;
  pulse_t pulse_log[$];

  opl3_host_if dut (
    .clk          (clk),
    .ic_n         (ic_n),
    .host_wr_en   (host_wr_en),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .overflow_clr (overflow_clr),
`ifdef OPL3_HOST_STATUS_EN
    .host_rd_en   (host_rd_en),
    .host_rd_data (host_rd_data),
`endif
    .opl3_reg_wr  (opl3_reg_wr),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (opl3_reg_wr[17]) pulse_log.push_back('{cyc, opl3_reg_wr[16:0]});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic drive_cycle(input logic we, input logic [1:0] a, input logic [7:0] d);
    host_wr_en = we;
    host_addr  = a;
    host_data  = d;
    @(posedge clk);
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    ic_n = 1'b0;
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (opl3_reg_wr[17]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  a;
    logic [7:0]  d;
    int          hold;
    logic [17:0] exp_wr;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   p;
    int   base;
    bit   ok;

    // {valid, bank, address, data}
    vecs[0] = '{1'b1, 2'b00, 8'h20, 1,  18'h00000, 0};
    vecs[1] = '{1'b1, 2'b01, 8'h01, 1,  18'h00000, 1};
    vecs[2] = '{1'b0, 2'b00, 8'h00, 1,  18'h22001, 0};
    vecs[3] = '{1'b0, 2'b00, 8'h00, 1,  18'h02001, 0};
    vecs[4] = '{1'b1, 2'b10, 8'hB0, 1,  18'h02001, 0};
    vecs[5] = '{1'b1, 2'b01, 8'h31, 1,  18'h02001, 1};
    vecs[6] = '{1'b0, 2'b00, 8'h00, 29, 18'h3B031, 0};
    vecs[7] = '{1'b1, 2'b11, 8'h44, 1,  18'h1B031, 1};
    vecs[8] = '{1'b0, 2'b00, 8'h00, 31, 18'h3B044, 0};
    vecs[9] = '{1'b0, 2'b00, 8'h00, 1,  18'h1B044, 0};

    @(negedge clk);
    do_reset();
    chk("reset_wr", 32'(opl3_reg_wr), 0);
    chk("reset_count", 32'(fifo_count), 0);
    chk("reset_full", 32'(fifo_full), 0);
    chk("reset_overflow", 32'(overflow), 0);

    // Decode, latency, bank select and bank persistence
    for (int i = 0; i < 10; i++) begin
      drive_cycle(vecs[i].we, vecs[i].a, vecs[i].d);
      for (int h = 1; h < vecs[i].hold; h++) drive_cycle(1'b0, 2'b00, 8'h00);
      chk($sformatf("vec%0d_wr", i), 32'(opl3_reg_wr), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
    end

    // Three back-to-back data writes drain 32 cycles apart in order
    do_reset();
    base = pulse_log.size();
    drive_cycle(1'b1, 2'b01, 8'hA1);
    drive_cycle(1'b1, 2'b01, 8'hA2);
    drive_cycle(1'b1, 2'b01, 8'hA3);
    repeat (100) @(negedge clk);
    chk("spacing_pulses", 32'(pulse_log.size() - base), 3);
    if (pulse_log.size() - base >= 3) begin
      chk("spacing_p0", 32'(pulse_log[base].p), 32'h000A1);
      chk("spacing_p1", 32'(pulse_log[base+1].p), 32'h000A2);
      chk("spacing_p2", 32'(pulse_log[base+2].p), 32'h000A3);
      chk("spacing_gap01", 32'(pulse_log[base+1].cyc - pulse_log[base].cyc), 32);
      chk("spacing_gap12", 32'(pulse_log[base+2].cyc - pulse_log[base+1].cyc), 32);
    end

    // Fill while the spacing counter is busy; 9th write is dropped
    do_reset();
    drive_cycle(1'b1, 2'b01, 8'h10);
    drive_cycle(1'b0, 2'b00, 8'h00);
    p = cyc;
    chk("fill_first_pulse", 32'(opl3_reg_wr), 32'h20010);
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 2'b01, 8'(8'h80 + i));
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_count", 32'(fifo_count), 8);
    chk("fill_overflow", 32'(overflow), 1);
`ifdef OPL3_HOST_STATUS_EN
    host_rd_en = 1'b1;
    drive_cycle(1'b0, 2'b00, 8'h00);
    host_rd_en = 1'b0;
    chk("status_byte", 32'(host_rd_data), 32'hC8);
    chk("status_clears_overflow", 32'(overflow), 0);
`else
    overflow_clr = 1'b1;
    drive_cycle(1'b0, 2'b00, 8'h00);
    overflow_clr = 1'b0;
    chk("overflow_clr", 32'(overflow), 0);
`endif
    overflow_clr = 1'b1;
    drive_cycle(1'b1, 2'b01, 8'h99);
    overflow_clr = 1'b0;
    chk("set_wins_overflow", 32'(overflow), 1);
    chk("set_wins_count", 32'(fifo_count), 8);
    overflow_clr = 1'b1;
    drive_cycle(1'b0, 2'b00, 8'h00);
    overflow_clr = 1'b0;
    chk("overflow_clr2", 32'(overflow), 0);

    // Full FIFO: push lands on the pop edge (first pop was at cycle p)
    while (cyc < p + 31) @(negedge clk);
    drive_cycle(1'b1, 2'b01, 8'hEE);
    chk("fullpop_wr", 32'(opl3_reg_wr), 32'h20080);
    chk("fullpop_count", 32'(fifo_count), 8);
    chk("fullpop_full", 32'(fifo_full), 1);
    chk("fullpop_overflow", 32'(overflow), 0);

    // Async reset with four entries queued and a pulse in flight
    do_reset();
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 2'b01, 8'(8'h60 + i));
    wait_valid(60, ok);
    chk("rst_wait_pulse", 32'(ok), 1);
    chk("rst_pre_wr", 32'(opl3_reg_wr), 32'h20061);
    chk("rst_pre_count", 32'(fifo_count), 4);
    #2 ic_n = 1'b0;
    #1;
    chk("rst_async_wr", 32'(opl3_reg_wr), 0);
    chk("rst_async_count", 32'(fifo_count), 0);
    @(negedge clk);
    ic_n = 1'b1;
    base = pulse_log.size();
    repeat (80) @(negedge clk);
    chk("rst_no_pulses", 32'(pulse_log.size() - base), 0);
    drive_cycle(1'b1, 2'b01, 8'h77);
    drive_cycle(1'b0, 2'b00, 8'h00);
    chk("rst_new_write", 32'(opl3_reg_wr), 32'h20077);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
